// File: rtl/fx_accum_seq.sv
// Block sequencer for the pipelined FX datapath: feeds one sample at a time
// with the running sum, waits out the datapath latency, and captures the result as the new sum.
module fx_accum_seq #(
   parameter int LATENCY = 40,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   input  logic             in_valid,
   input  logic [31:0]      in_data,
   output logic             in_ready,
   output logic             fx_clk_en,
   output logic [31:0]      fx_dataa,
   output logic [31:0]      fx_datab,
   input  logic [31:0]      fx_result,
   output logic             busy,
   output logic             done,
   output logic [31:0]      sum
);

   localparam int WAIT_W = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
   localparam logic [WAIT_W-1:0] LAT_CNT = WAIT_W'(LATENCY);

   // Handshake: a sample is consumed in any cycle where in_valid && in_ready.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   remaining_q;
   logic [WAIT_W-1:0]  wait_cnt_q;
   logic [31:0]        dataa_q;
   logic [31:0]        datab_q;
   logic [31:0]        sum_q;
   logic               busy_q;
   logic               done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         remaining_q <= '0;
         wait_cnt_q  <= '0;
         dataa_q     <= '0;
         datab_q     <= '0;
         sum_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  remaining_q <= count;
                  sum_q       <= '0;
                  busy_q      <= 1'b1;
                  if (count == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (in_valid) begin
                  dataa_q    <= in_data;
                  datab_q    <= sum_q;
                  wait_cnt_q <= '0;
                  state_q    <= S_WAIT;
               end
            end
            S_WAIT: begin
               // The result for the presented operands is valid in the LATENCY-th wait cycle.
               if (wait_cnt_q == LAT_CNT) begin
                  sum_q       <= fx_result;
                  remaining_q <= remaining_q - CNT_W'(1);
                  if (remaining_q == CNT_W'(1)) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_FETCH;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == S_FETCH);
   assign fx_clk_en = (state_q != S_IDLE);
   assign fx_dataa  = dataa_q;
   assign fx_datab  = datab_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sum       = sum_q;

endmodule

// File: tb/tb_fx_accum_seq.sv
// Directed bench for fx_accum_seq with a LATENCY-deep adder stub standing in for the FX datapath.
module tb_fx_accum_seq;

   localparam int LAT = 4;
   localparam int CW  = 4;
   localparam logic [31:0] F1  = 32'h3F80_0000;
   localparam logic [31:0] F2  = 32'h4000_0000;
   localparam logic [31:0] F3  = 32'h4040_0000;
   localparam logic [31:0] F4  = 32'h4080_0000;
   localparam logic [31:0] F5  = 32'h40A0_0000;
   localparam logic [31:0] F7  = 32'h40E0_0000;
   localparam logic [31:0] NAN = 32'h7FC0_1234;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] count;
   logic          in_valid;
   logic [31:0]   in_data;
   logic          in_ready;
   logic          fx_clk_en;
   logic [31:0]   fx_dataa;
   logic [31:0]   fx_datab;
   logic [31:0]   fx_result;
   logic          busy;
   logic          done;
   logic [31:0]   sum;

   int checks   = 0;
   int failures = 0;

   fx_accum_seq #(.LATENCY(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .count(count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .fx_clk_en(fx_clk_en), .fx_dataa(fx_dataa), .fx_datab(fx_datab),
      .fx_result(fx_result), .busy(busy), .done(done), .sum(sum)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // float <-> integer helpers, valid for small non-negative integers
   function automatic int unsigned f2i(input logic [31:0] f);
      int e;
      logic [31:0] m;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]) - 127;
      if (e < 0) return 0;
      m = {8'd0, 1'b1, f[22:0]};
      if (e > 23) return m << (e - 23);
      return m >> (23 - e);
   endfunction

   function automatic logic [31:0] i2f(input int unsigned v);
      int p;
      logic [31:0] m;
      logic [7:0] ex;
      if (v == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 32; i++) if (v[i]) p = i;
      m  = (p <= 23) ? (v << (23 - p)) : (v >> (p - 23));
      ex = 8'(p + 127);
      return {1'b0, ex, m[22:0]};
   endfunction

   // datapath stub: LATENCY stages, advancing only while fx_clk_en is high
   bit stub_nan = 1'b0;
   logic [31:0] pipe [LAT];
   always @(posedge clk) begin
      if (fx_clk_en) begin
         pipe[0] <= stub_nan ? NAN : i2f(f2i(fx_dataa) + f2i(fx_datab));
         for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign fx_result = pipe[LAT-1];

   // monitor: records event cycles relative to block start, tracks operand stability
   int base   = 0;
   int blk_id = 0;
   int seen_id = 0;
   int done_at[$];
   int rdy_at[$];
   int en_cnt;
   int unstable;
   bit armed;
   logic [31:0] exp_a, exp_b;
   always @(negedge clk) begin
      if (blk_id != seen_id) begin
         seen_id = blk_id;
         done_at.delete();
         rdy_at.delete();
         en_cnt   = 0;
         unstable = 0;
      end
      if (done) done_at.push_back(cyc - base);
      if (in_ready) rdy_at.push_back(cyc - base);
      if (fx_clk_en) en_cnt++;
      if (armed && (fx_dataa !== exp_a || fx_datab !== exp_b)) unstable++;
      if (in_ready && in_valid) begin
         armed = 1'b1;
         exp_a = in_data;
         exp_b = sum;
      end
      if (rst) armed = 1'b0;
   end

   function automatic int done_get(input int i);
      return (i < done_at.size()) ? done_at[i] : -1;
   endfunction

   function automatic int rdy_get(input int i);
      return (i < rdy_at.size()) ? rdy_at[i] : -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic goto_cycle(input int k);
      while (cyc - base < k) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic begin_block(input logic [CW-1:0] cnt, input logic [31:0] x0, input logic vld);
      @(posedge clk);
      #1;
      base     = cyc;
      blk_id   = blk_id + 1;
      start    = 1'b1;
      count    = cnt;
      in_valid = vld;
      in_data  = x0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_sum", sum, 32'd0);
      check("rst_dataa", fx_dataa, 32'd0);
      check("rst_datab", fx_datab, 32'd0);
      check("rst_ready", {31'd0, in_ready}, 32'd0);
      check("rst_clken", {31'd0, fx_clk_en}, 32'd0);

      // three samples, in_valid held high
      begin_block(4'd3, F1, 1'b1);
      goto_cycle(1); start = 1'b0;
      goto_cycle(2); in_data = F2;
      goto_cycle(8); in_data = F3;
      goto_cycle(14); in_data = 32'h0;
      goto_cycle(22);
      check("t1_done_n", done_at.size(), 1);
      check("t1_done_cyc", done_get(0), 19);
      check("t1_rdy_n", rdy_at.size(), 3);
      check("t1_rdy0", rdy_get(0), 1);
      check("t1_rdy1", rdy_get(1), 7);
      check("t1_rdy2", rdy_get(2), 13);
      check("t1_sum", sum, 32'h40C0_0000);
      check("t1_busy", {31'd0, busy}, 32'd0);
      check("t1_stable", unstable, 0);

      // empty block
      begin_block(4'd0, F1, 1'b0);
      goto_cycle(1); start = 1'b0;
      goto_cycle(6);
      check("t2_done_n", done_at.size(), 1);
      check("t2_done_cyc", done_get(0), 1);
      check("t2_rdy_n", rdy_at.size(), 0);
      check("t2_clken_n", en_cnt, 1);
      check("t2_sum", sum, 32'd0);

      // stall of 5 cycles before the second sample
      begin_block(4'd2, F5, 1'b1);
      goto_cycle(1); start = 1'b0;
      goto_cycle(2); in_valid = 1'b0; in_data = F7;
      goto_cycle(12); in_valid = 1'b1;
      goto_cycle(13); in_valid = 1'b0;
      goto_cycle(22);
      check("t3_done_cyc", done_get(0), 18);
      check("t3_done_n", done_at.size(), 1);
      check("t3_rdy_n", rdy_at.size(), 7);
      check("t3_rdy_last", rdy_get(6), 12);
      check("t3_sum", sum, 32'h4140_0000);
      check("t3_stable", unstable, 0);

      // start pulses and count changes while busy are ignored
      begin_block(4'd2, F1, 1'b1);
      goto_cycle(1); count = 4'd5;
      goto_cycle(2); start = 1'b0; in_data = F2; count = 4'd2;
      goto_cycle(4); start = 1'b1; count = 4'd9;
      goto_cycle(5); start = 1'b0;
      goto_cycle(13); start = 1'b1; count = 4'd1;
      goto_cycle(14); start = 1'b0;
      goto_cycle(22);
      check("t4_done_n", done_at.size(), 1);
      check("t4_done_cyc", done_get(0), 13);
      check("t4_rdy_n", rdy_at.size(), 2);
      check("t4_rdy1", rdy_get(1), 7);
      check("t4_sum", sum, 32'h4040_0000);
      check("t4_busy", {31'd0, busy}, 32'd0);

      // NaN result passes through bit-for-bit
      stub_nan = 1'b1;
      begin_block(4'd1, F1, 1'b1);
      goto_cycle(1); start = 1'b0;
      goto_cycle(10);
      check("t5_done_cyc", done_get(0), 7);
      check("t5_sum", sum, NAN);
      stub_nan = 1'b0;

      // reset in the middle of the second sample's wait
      begin_block(4'd3, F1, 1'b1);
      goto_cycle(1); start = 1'b0;
      goto_cycle(2); in_data = F2;
      goto_cycle(8); in_data = F3;
      goto_cycle(10);
      check("t6_pre_sum", sum, F1);
      rst = 1'b1;
      goto_cycle(11); rst = 1'b0;
      check("t6_busy", {31'd0, busy}, 32'd0);
      check("t6_done", {31'd0, done}, 32'd0);
      check("t6_sum", sum, 32'd0);
      check("t6_dataa", fx_dataa, 32'd0);
      check("t6_datab", fx_datab, 32'd0);
      check("t6_ready", {31'd0, in_ready}, 32'd0);
      check("t6_clken", {31'd0, fx_clk_en}, 32'd0);
      goto_cycle(25);
      check("t6_late_sum", sum, 32'd0);
      check("t6_no_done", done_at.size(), 0);

      begin_block(4'd1, F4, 1'b1);
      goto_cycle(1); start = 1'b0;
      goto_cycle(10);
      check("t6b_done_cyc", done_get(0), 7);
      check("t6b_sum", sum, F4);

      // all-ones count completes without wrap
      begin_block(4'd15, F1, 1'b1);
      goto_cycle(1); start = 1'b0;
      goto_cycle(95);
      check("t7_done_n", done_at.size(), 1);
      check("t7_done_cyc", done_get(0), 91);
      check("t7_rdy_n", rdy_at.size(), 15);
      check("t7_sum", sum, 32'h4170_0000);
      check("t7_stable", unstable, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
